// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
// Prefix bytes, frame bit positions and the buffered key event.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [3:0] BIT_START = 4'd0;
    localparam logic [3:0] BIT_D0    = 4'd1;
    localparam logic [3:0] BIT_D7    = 4'd8;
    localparam logic [3:0] BIT_PAR   = 4'd9;
    localparam logic [3:0] BIT_STOP  = 4'd10;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_evt_t;

    function automatic logic odd_par_ok(input logic [7:0] d,
                                        input logic       p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead event FIFO for decoded key events.
// Level counts 0..DEPTH; a push into a full FIFO is dropped unless a pop frees a slot.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  ps2_evt_t               din,
    input  logic                   pop,
    output ps2_evt_t               dout,
    output logic                   full,
    output logic                   empty,
    output logic                   drop,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    ps2_evt_t      mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~pop;
    // Stale storage is hidden while empty so the head reads as zero.
    assign dout    = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: pin sync, frame capture with timeout,
// E0/F0 prefix decode and a buffered make/break event stream.
module ps2_kbd_rx_fifo
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [7:0]                    raw_data,
    output logic                          raw_valid,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_rel,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_ovf,
    output logic                          err_parity,
    output logic                          err_frame,
    output logic [ERR_CNT_W-1:0]          err_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   s_pulse;
    logic                   s_bit;

    logic [3:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   par_bit;
    logic [TW-1:0]          tmo_cnt;

    logic                   ext_f;
    logic                   rel_f;
    logic                   is_ext;
    logic                   is_brk;
    logic                   err_any;

    logic                   push;
    ps2_evt_t               push_evt;
    ps2_evt_t               head;
    logic                   full;
    logic                   empty;
    logic                   drop;

    // Sync flops idle high so reset never fakes a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign s_pulse = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
    assign s_bit   = dat_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= BIT_START;
            shreg      <= '0;
            par_bit    <= 1'b0;
            tmo_cnt    <= '0;
            raw_data   <= '0;
            raw_valid  <= 1'b0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            raw_valid  <= 1'b0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            if (s_pulse) begin
                tmo_cnt <= '0;
                if (bit_cnt == BIT_START) begin
                    if (!s_bit) begin
                        bit_cnt <= BIT_D0;
                    end
                end else if (bit_cnt <= BIT_D7) begin
                    shreg   <= {s_bit, shreg[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == BIT_PAR) begin
                    par_bit <= s_bit;
                    bit_cnt <= BIT_STOP;
                end else begin
                    bit_cnt <= BIT_START;
                    if (!odd_par_ok(shreg, par_bit)) begin
                        err_parity <= 1'b1;
                    end else if (!s_bit) begin
                        err_frame <= 1'b1;
                    end else begin
                        raw_valid <= 1'b1;
                        raw_data  <= shreg;
                    end
                end
            end else if (bit_cnt != BIT_START) begin
                // A stalled partial frame is abandoned after the timeout.
                if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    tmo_cnt   <= '0;
                    bit_cnt   <= BIT_START;
                    err_frame <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    assign err_any = err_parity | err_frame;
    assign is_ext  = (raw_data == PS2_EXT);
    assign is_brk  = (raw_data == PS2_BRK);
    assign push    = raw_valid & ~is_ext & ~is_brk;

    always_comb begin
        push_evt      = '0;
        push_evt.ext  = ext_f;
        push_evt.rel  = rel_f;
        push_evt.code = raw_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_f <= 1'b0;
            rel_f <= 1'b0;
        end else if (err_any) begin
            ext_f <= 1'b0;
            rel_f <= 1'b0;
        end else if (raw_valid) begin
            unique case (1'b1)
                is_ext: ext_f <= 1'b1;
                is_brk: rel_f <= 1'b1;
                default: begin
                    ext_f <= 1'b0;
                    rel_f <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_any && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

    // A drop in the same cycle as clr_ovf keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_evt),
        .pop   (evt_ready),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .drop  (drop),
        .level (fifo_level)
    );

    assign evt_valid = ~empty;
    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_rel   = head.rel;

endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// Scoreboard bench for ps2_kbd_rx_fifo.
// Stimulus queues expected bytes/events/errors; a monitor pops and compares.
module tb_ps2_kbd_rx_fifo;
    import ps2_pkg::*;

    localparam int DEPTH = 8;
    localparam int TMO   = 100;
    localparam int ECW   = 8;
    localparam int HALF  = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ps2_clk;
    logic             ps2_data;
    logic [7:0]       raw_data;
    logic             raw_valid;
    logic             evt_valid;
    logic             evt_ready;
    logic [7:0]       evt_code;
    logic             evt_ext;
    logic             evt_rel;
    logic [3:0]       fifo_level;
    logic             overflow;
    logic             clr_ovf;
    logic             err_parity;
    logic             err_frame;
    logic [ECW-1:0]   err_cnt;

    logic [7:0] raw_q [$];
    ps2_evt_t   evt_q [$];
    logic [1:0] err_q [$];

    int    n_pass  = 0;
    int    n_total = 0;
    longint cyc    = 0;
    longint raw_cyc = 0;
    logic  chk_lat = 1'b0;
    logic  evt_prev = 1'b0;

    ps2_kbd_rx_fifo #(
        .SYNC_STAGES (3),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO),
        .ERR_CNT_W   (ECW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .raw_data   (raw_data),
        .raw_valid  (raw_valid),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_rel    (evt_rel),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .err_parity (err_parity),
        .err_frame  (err_frame),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit stop, input int nbits);
        logic [10:0] bits;
        bits = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
        ps2_data = 1'b1;
        tick(HALF);
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11);
    endtask

    task automatic exp_raw(input logic [7:0] b);
        raw_q.push_back(b);
    endtask

    task automatic exp_evt(input logic e, input logic r, input logic [7:0] c);
        ps2_evt_t v;
        v.ext  = e;
        v.rel  = r;
        v.code = c;
        evt_q.push_back(v);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (raw_valid) begin
                if (raw_q.size() == 0) chk("raw_unexpected", 32'(raw_data), 32'hFFFF);
                else chk("raw_data", 32'(raw_data), 32'(raw_q.pop_front()));
                raw_cyc = cyc;
            end
            if (chk_lat && evt_valid && !evt_prev) begin
                chk("evt_latency", 32'(cyc - raw_cyc), 32'd1);
                chk_lat = 1'b0;
            end
            evt_prev = evt_valid;
            if (evt_valid && evt_ready) begin
                if (evt_q.size() == 0)
                    chk("evt_unexpected", {22'b0, evt_ext, evt_rel, evt_code}, 32'hFFFF);
                else
                    chk("evt", {22'b0, evt_ext, evt_rel, evt_code}, 32'(evt_q.pop_front()));
            end
            if (err_parity || err_frame) begin
                if (err_q.size() == 0)
                    chk("err_unexpected", {30'b0, err_parity, err_frame}, 32'hFFFF);
                else
                    chk("err_kind", {30'b0, err_parity, err_frame}, 32'(err_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] codes [9];
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        evt_ready = 1'b1; clr_ovf = 1'b0;
        tick(3);
        chk("rst_raw", {23'b0, raw_valid, raw_data}, 32'd0);
        chk("rst_evt", {21'b0, evt_valid, evt_ext, evt_rel, evt_code}, 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_flags", {29'b0, overflow, err_parity, err_frame}, 32'd0);
        chk("rst_errcnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        tick(5);

        // 1: basic make code with latency check
        chk_lat = 1'b1;
        exp_raw(8'h1C); exp_evt(1'b0, 1'b0, 8'h1C);
        good(8'h1C);
        tick(10);
        chk("t1_errcnt", 32'(err_cnt), 32'd0);
        chk("t1_latency_seen", 32'(chk_lat), 32'd0);

        // lone falling edge with data high must be ignored
        ps2_bit(1'b1);
        exp_raw(8'h1B); exp_evt(1'b0, 1'b0, 8'h1B);
        good(8'h1B);

        // 2: E0 F0 75
        exp_raw(8'hE0); exp_raw(8'hF0); exp_raw(8'h75);
        exp_evt(1'b1, 1'b1, 8'h75);
        good(8'hE0); good(8'hF0); good(8'h75);

        // 3: parity error, stop error, prefix cleared by error
        err_q.push_back(2'b10);
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        tick(5);
        chk("t3_errcnt", 32'(err_cnt), 32'd1);
        exp_raw(8'h32); exp_evt(1'b0, 1'b0, 8'h32);
        good(8'h32);
        err_q.push_back(2'b01);
        send_frame(8'h1C, 1'b0, 1'b0, 11);
        tick(5);
        chk("t3_stop_errcnt", 32'(err_cnt), 32'd2);
        exp_raw(8'hE0);
        good(8'hE0);
        err_q.push_back(2'b10);
        send_frame(8'h2A, 1'b1, 1'b1, 11);
        exp_raw(8'h2A); exp_evt(1'b0, 1'b0, 8'h2A);
        good(8'h2A);

        // 4: stall mid-frame
        err_q.push_back(2'b01);
        send_frame(8'h23, 1'b0, 1'b1, 5);
        tick(TMO + 50);
        chk("t4_errcnt", 32'(err_cnt), 32'd4);
        exp_raw(8'h23); exp_evt(1'b0, 1'b0, 8'h23);
        good(8'h23);
        tick(5);

        // 5: overflow with consumer stalled
        evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            exp_raw(codes[i]);
            if (i < DEPTH) exp_evt(1'b0, 1'b0, codes[i]);
            good(codes[i]);
        end
        tick(5);
        chk("t5_level", 32'(fifo_level), 32'(DEPTH));
        chk("t5_ovf", 32'(overflow), 32'd1);
        chk("t5_head", 32'(evt_code), 32'h15);
        evt_ready = 1'b1;
        for (int i = 0; i < 50 && evt_valid; i++) tick(1);
        chk("t5_drained", 32'(fifo_level), 32'd0);
        chk("t5_ovf_sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk("t5_ovf_clr", 32'(overflow), 32'd0);

        // 6: reset mid-frame after E0
        exp_raw(8'hE0);
        good(8'hE0);
        send_frame(8'h55, 1'b0, 1'b1, 4);
        rst_n = 1'b0;
        tick(1);
        chk("t6_rst_out", {20'b0, raw_valid, evt_valid, overflow, err_parity,
                           err_frame, fifo_level, 3'b0}, 32'd0);
        chk("t6_rst_errcnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        tick(5);
        chk_lat = 1'b1;
        exp_raw(8'h1C); exp_evt(1'b0, 1'b0, 8'h1C);
        good(8'h1C);
        tick(20);

        chk("end_raw_q", 32'(raw_q.size()), 32'd0);
        chk("end_evt_q", 32'(evt_q.size()), 32'd0);
        chk("end_err_q", 32'(err_q.size()), 32'd0);
        chk("end_errcnt", 32'(err_cnt), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
